// File: rtl/ring_supervisor_pkg.sv
// Shared types and constants for the NCL ring supervisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ring_supervisor_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    STALLED = 2'd3
  } ring_sup_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int RESTART_W   = 8;

  // Saturating increment for the restart counter.
  function automatic logic [RESTART_W-1:0] restart_inc(input logic [RESTART_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ring_supervisor_if.sv
// Bundle of ring-facing and measurement signals of the ring supervisor.
// Latency: n/a; master = supervisor (drives ring_init and results), slave = ring/board side.
// Backpressure: none, meas_valid is a one-cycle strobe with no ready.
interface ring_supervisor_if
  import ring_supervisor_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic                 start;
  logic                 ring_tap;
  logic                 ring_init;
  logic                 running;
  logic [CNT_W-1:0]     meas_count;
  logic                 meas_valid;
  logic                 stalled;
  logic [RESTART_W-1:0] restarts;

  modport master (
    input  start, ring_tap,
    output ring_init, running, meas_count, meas_valid, stalled, restarts
  );

  modport slave (
    output start, ring_tap,
    input  ring_init, running, meas_count, meas_valid, stalled, restarts
  );

endinterface

// File: rtl/ring_supervisor_sync_rise.sv
// sync_rise: DEPTH-flop synchroniser for an asynchronous level plus rising-edge pulse.
// Latency: pulse is high in the cycle after the edge DEPTH clocks past the input rise.
// Backpressure: none. Ports: clk, rst_n, din (async), rise (1-cycle pulse, 0 after reset).
module sync_rise #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [DEPTH-1:0] sync_q;
  logic             prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], din};
      prev_q <= sync_q[DEPTH-1];
    end
  end

  assign rise = sync_q[DEPTH-1] & ~prev_q;

endmodule

// File: rtl/ring_supervisor.sv
// ring_supervisor: holds an NCL ring in init, releases it, counts tap rising edges per
// 2^WINDOW_LOG2-cycle window and recovers from stalls. Ports: clk, rst_n, bus (master:
// start, ring_tap in; ring_init, running, meas_count, meas_valid, stalled, restarts out).
// Latency: tap edge counted 3 clocks after it rises. Backpressure: none (strobe output).
// Build option RING_SUPERVISOR_AUTORESTART_EN: a stall re-initialises the ring and bumps
// restarts; otherwise the block parks in STALLED until start and restarts stays 0.
module ring_supervisor
  import ring_supervisor_pkg::*;
#(
  parameter int INIT_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_LOG2   = 20,
  parameter int CNT_W         = 16,
  parameter int STALL_LIMIT   = 2
) (
  input logic              clk,
  input logic              rst_n,
  ring_supervisor_if.master bus
);

  localparam int PH_MAX  = (INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int STALL_W = 4;

  ring_sup_state_t      state;
  logic [PH_W-1:0]      phase_cnt;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]     edge_cnt;
  logic [STALL_W-1:0]   stall_cnt;

  logic                 ring_init_q;
  logic                 running_q;
  logic [CNT_W-1:0]     meas_count_q;
  logic                 meas_valid_q;
  logic                 stalled_q;
  logic [RESTART_W-1:0] restarts_q;

  logic                 tap_rise;
  logic                 win_last;
  logic [CNT_W-1:0]     edge_next;
  logic [STALL_W-1:0]   stall_next;
  logic                 stall_now;
  logic                 auto_restart;
  logic                 stall_stop;

  sync_rise #(.DEPTH(SYNC_STAGES)) u_tap_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.ring_tap),
    .rise  (tap_rise)
  );

  assign win_last   = &win_cnt;
  // Count including an edge seen this cycle, saturating at all-ones.
  assign edge_next  = (tap_rise && !(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;
  assign stall_next = stall_cnt + 1'b1;
  // A user start on the same cycle wins over stall handling.
  assign stall_now  = (state == MEASURE) && win_last && (edge_next == '0) &&
                      (stall_next == STALL_W'(STALL_LIMIT)) && !bus.start;

`ifdef RING_SUPERVISOR_AUTORESTART_EN
  assign auto_restart = stall_now;
  assign stall_stop   = 1'b0;
`else
  assign auto_restart = 1'b0;
  assign stall_stop   = stall_now;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      phase_cnt    <= PH_W'(INIT_CYCLES - 1);
      win_cnt      <= '0;
      edge_cnt     <= '0;
      stall_cnt    <= '0;
      ring_init_q  <= 1'b1;
      running_q    <= 1'b0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      stalled_q    <= 1'b0;
      restarts_q   <= '0;
    end else begin
      meas_valid_q <= 1'b0;

      // Window bookkeeping; the result of a window ending this cycle is always
      // published, even if a start or stall changes state on the same edge.
      if (state == MEASURE) begin
        win_cnt <= win_cnt + 1'b1;
        if (win_last) begin
          meas_count_q <= edge_next;
          meas_valid_q <= 1'b1;
          edge_cnt     <= '0;
          if (edge_next == '0) begin
            stall_cnt <= stall_next;
          end else begin
            stall_cnt <= '0;
            stalled_q <= 1'b0;
          end
        end else begin
          edge_cnt <= edge_next;
        end
      end

      if (bus.start || auto_restart) begin
        state       <= INIT;
        phase_cnt   <= PH_W'(INIT_CYCLES - 1);
        win_cnt     <= '0;
        edge_cnt    <= '0;
        stall_cnt   <= '0;
        ring_init_q <= 1'b1;
        running_q   <= 1'b0;
        stalled_q   <= auto_restart;
        if (auto_restart) restarts_q <= restart_inc(restarts_q);
      end else if (stall_stop) begin
        state     <= STALLED;
        running_q <= 1'b0;
        stalled_q <= 1'b1;
      end else begin
        case (state)
          INIT: begin
            if (phase_cnt == '0) begin
              state       <= SETTLE;
              ring_init_q <= 1'b0;
              phase_cnt   <= PH_W'(SETTLE_CYCLES - 1);
            end else begin
              phase_cnt <= phase_cnt - 1'b1;
            end
          end
          SETTLE: begin
            if (phase_cnt == '0) begin
              state     <= MEASURE;
              running_q <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ring_init  = ring_init_q;
  assign bus.running    = running_q;
  assign bus.meas_count = meas_count_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.stalled    = stalled_q;
  assign bus.restarts   = restarts_q;

endmodule
